// File: rtl/keypad_event_scanner_if.sv
// ============================================================================
// Module  : keypad_event_scanner_if
// Purpose : Keypad matrix lines and decoded key-event outputs for the scanner.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface keypad_event_scanner_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // master is the scanner; slave is the keypad plus the event consumer
    modport master (
        input  ROW,
        output COL,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output ROW,
        input  COL,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

`default_nettype wire

// File: rtl/keypad_event_scanner.sv
// ============================================================================
// Module  : keypad_event_scanner
// Purpose : 4x4 keypad column scanner with sweep-level debounce; one strobe
//           per newly accepted key press, no auto-repeat.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_event_scanner #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input wire logic               CLK,
    input wire logic               reset,
    keypad_event_scanner_if.master kp
);

    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam int               CNT_W      = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(DEBOUNCE_SWEEPS);

    typedef enum logic [1:0] {
        ST_NONE  = 2'd0,
        ST_KEY   = 2'd1,
        ST_MULTI = 2'd2
    } sweep_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_col_drv;
    logic [1:0]       r_npress;
    logic [3:0]       r_acc_code;
    sweep_t           r_cand_kind;
    logic [3:0]       r_cand_code;
    sweep_t           r_stable_kind;
    logic [3:0]       r_stable_code;
    logic [CNT_W-1:0] r_match;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    logic             w_win_end;
    logic [2:0]       w_col_cnt;
    logic [1:0]       w_col_row;
    logic [2:0]       w_sum;
    logic [1:0]       w_npress_next;
    logic [3:0]       w_code_next;
    sweep_t           w_res_kind;
    logic [3:0]       w_res_code;
    sweep_t           w_cand_kind_next;
    logic [3:0]       w_cand_code_next;
    logic [CNT_W-1:0] w_match_next;
    logic             w_accept;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] c;
        case ({row, col})
            4'h0:    c = 4'h1;
            4'h1:    c = 4'h2;
            4'h2:    c = 4'h3;
            4'h3:    c = 4'hA;
            4'h4:    c = 4'h4;
            4'h5:    c = 4'h5;
            4'h6:    c = 4'h6;
            4'h7:    c = 4'hB;
            4'h8:    c = 4'h7;
            4'h9:    c = 4'h8;
            4'hA:    c = 4'h9;
            4'hB:    c = 4'hC;
            4'hC:    c = 4'h0;
            4'hD:    c = 4'hF;
            4'hE:    c = 4'hE;
            default: c = 4'hD;
        endcase
        return c;
    endfunction

    assign w_win_end = (r_div == C_DIV_LAST);

    // Per-column sample folded into the running sweep tally (count saturates at 2)
    always_comb begin
        w_col_cnt = 3'd0;
        w_col_row = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (!r_sync2[j]) begin
                w_col_cnt = w_col_cnt + 3'd1;
                w_col_row = 2'(j);
            end
        end
        w_code_next = r_acc_code;
        if (w_col_cnt == 3'd1) begin
            w_code_next = key_lookup(w_col_row, r_col);
        end
        w_sum         = {1'b0, r_npress} + w_col_cnt;
        w_npress_next = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    end

    always_comb begin
        case (w_npress_next)
            2'd0:    w_res_kind = ST_NONE;
            2'd1:    w_res_kind = ST_KEY;
            default: w_res_kind = ST_MULTI;
        endcase
        w_res_code = (w_res_kind == ST_KEY) ? w_code_next : 4'h0;

        if ({w_res_kind, w_res_code} == {r_cand_kind, r_cand_code}) begin
            w_cand_kind_next = r_cand_kind;
            w_cand_code_next = r_cand_code;
            w_match_next     = (r_match == C_CNT_MAX) ? r_match : r_match + CNT_W'(1);
        end else begin
            w_cand_kind_next = w_res_kind;
            w_cand_code_next = w_res_code;
            w_match_next     = CNT_W'(1);
        end

        w_accept = (w_match_next == C_CNT_MAX)
                && (w_cand_kind_next != ST_MULTI)
                && ({w_cand_kind_next, w_cand_code_next} != {r_stable_kind, r_stable_code});
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync1       <= 4'hF;
            r_sync2       <= 4'hF;
            r_div         <= '0;
            r_col         <= 2'd0;
            r_col_drv     <= 4'b1110;
            r_npress      <= 2'd0;
            r_acc_code    <= 4'h0;
            r_cand_kind   <= ST_NONE;
            r_cand_code   <= 4'h0;
            r_stable_kind <= ST_NONE;
            r_stable_code <= 4'h0;
            r_match       <= '0;
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_held    <= 1'b0;
        end else begin
            r_sync1     <= kp.ROW;
            r_sync2     <= r_sync1;
            r_key_valid <= 1'b0;
            if (w_win_end) begin
                r_div     <= '0;
                r_col     <= r_col + 2'd1;
                r_col_drv <= {r_col_drv[2:0], r_col_drv[3]};
                if (r_col == 2'd3) begin
                    // Sweep boundary: judge the completed sweep, restart the tally
                    r_npress    <= 2'd0;
                    r_acc_code  <= 4'h0;
                    r_cand_kind <= w_cand_kind_next;
                    r_cand_code <= w_cand_code_next;
                    r_match     <= w_match_next;
                    if (w_accept) begin
                        r_stable_kind <= w_cand_kind_next;
                        r_stable_code <= w_cand_code_next;
                        if (w_cand_kind_next == ST_KEY) begin
                            r_key_code  <= w_cand_code_next;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                        end else begin
                            r_key_held  <= 1'b0;
                        end
                    end
                end else begin
                    r_npress   <= w_npress_next;
                    r_acc_code <= w_code_next;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign kp.COL       = r_col_drv;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_event_scanner.sv
// ============================================================================
// Module  : tb_keypad_event_scanner
// Purpose : Randomized sweep-level stimulus for keypad_event_scanner, checked
//           every cycle against a per-sweep behavioural debounce model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_event_scanner;

    localparam int SWEEP = 16;
    localparam int DS    = 3;
    localparam int MULTI = 16;
    localparam int NONE  = -1;
    // key code by matrix position row*4 + column
    localparam logic [3:0] CODE_TAB [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                             4'h4, 4'h5, 4'h6, 4'hB,
                                             4'h7, 4'h8, 4'h9, 4'hC,
                                             4'h0, 4'hF, 4'hE, 4'hD};

    logic        CLK;
    logic        reset;
    logic [15:0] pressed;

    keypad_event_scanner_if kp();

    keypad_event_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_SWEEPS (DS)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .kp    (kp)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Keypad matrix: a pressed key shorts its row to the driven-low column
    always_comb begin
        kp.ROW = 4'hF;
        for (int j = 0; j < 4; j++)
            for (int c = 0; c < 4; c++)
                if (!kp.COL[c] && pressed[j*4+c]) kp.ROW[j] = 1'b0;
    end

    int         n_checks;
    int         n_pass;
    int         m_cand;
    int         m_stable;
    int         m_cnt;
    logic [3:0] m_code;
    logic       m_held;
    logic       m_valid;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cand   = NONE;
        m_stable = NONE;
        m_cnt    = 0;
        m_code   = 4'h0;
        m_held   = 1'b0;
        m_valid  = 1'b0;
    endtask

    // One completed sweep with a constant set of pressed keys
    task automatic model_sweep(input logic [15:0] mask);
        int n;
        int res;
        n = $countones(mask);
        res = (n == 0) ? NONE : MULTI;
        if (n == 1)
            for (int i = 0; i < 16; i++)
                if (mask[i]) res = int'(CODE_TAB[i]);
        if (res == m_cand) m_cnt = (m_cnt < DS) ? m_cnt + 1 : DS;
        else begin
            m_cand = res;
            m_cnt  = 1;
        end
        if (m_cnt == DS && m_cand != MULTI && m_cand != m_stable) begin
            m_stable = m_cand;
            if (m_cand == NONE) m_held = 1'b0;
            else begin
                m_code  = 4'(m_cand);
                m_held  = 1'b1;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_cycle(input int k);
        logic [3:0] col_exp;
        col_exp = 4'hF ^ (4'h1 << ((k / 4) % 4));
        chk("COL",       {12'h0, kp.COL},       {12'h0, col_exp});
        chk("key_valid", {15'h0, kp.key_valid}, {15'h0, m_valid});
        chk("key_held",  {15'h0, kp.key_held},  {15'h0, m_held});
        chk("key_code",  {12'h0, kp.key_code},  {12'h0, m_code});
    endtask

    // Ends on the negedge where reset is dropped: cycle 0 of a fresh sweep
    task automatic apply_reset(input int n);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("rst_COL",       {12'h0, kp.COL},       16'h000E);
            chk("rst_key_valid", {15'h0, kp.key_valid}, 16'h0000);
            chk("rst_key_held",  {15'h0, kp.key_held},  16'h0000);
            chk("rst_key_code",  {12'h0, kp.key_code},  16'h0000);
        end
        reset = 1'b0;
    endtask

    // Entered and left at the negedge of cycle 0 of a sweep; rst_at < 0 means no reset
    task automatic run_sweep(input logic [15:0] mask, input int rst_at);
        pressed = mask;
        for (int k = 0; k < SWEEP; k++) begin
            check_cycle(k);
            m_valid = 1'b0;
            if (k == rst_at) begin
                apply_reset(2 + int'($urandom_range(0, 3)));
                return;
            end
            if (k == SWEEP - 1) model_sweep(mask);
            @(negedge CLK);
        end
    endtask

    task automatic run_n(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) run_sweep(mask, -1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pressed  = 16'h0;
        apply_reset(4);

        // idle scan, then key 5 held and released
        run_n(16'h0000, 2);
        run_n(16'h0020, 20);
        run_n(16'h0000, 6);

        // key 6 bouncing every sweep
        for (int i = 0; i < 12; i++) run_sweep((i % 2 == 0) ? 16'h0040 : 16'h0000, -1);
        run_n(16'h0000, 4);

        // keys 2 and 8 together, then 2 released
        run_n(16'h0202, 6);
        run_n(16'h0200, 5);
        run_n(16'h0000, 4);

        // key D interrupted by reset after two sweeps, then kept held
        run_n(16'h8000, 2);
        run_sweep(16'h8000, 5);
        run_n(16'h8000, 5);
        run_n(16'h0000, 4);

        // every key in turn, with direct key-to-key transitions
        for (int i = 0; i < 16; i++) run_n(16'(1 << i), 4);
        run_n(16'h0000, 4);

        // random runs of idle, single and double presses, occasional mid-sweep reset
        for (int r = 0; r < 120; r++) begin
            int          kind;
            int          len;
            int          a;
            int          b;
            logic [15:0] mask;
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 5));
            a    = int'($urandom_range(0, 15));
            b    = (a + 1 + int'($urandom_range(0, 14))) % 16;
            if (kind < 4)      mask = 16'h0;
            else if (kind < 8) mask = 16'(1 << a);
            else               mask = 16'(1 << a) | 16'(1 << b);
            for (int s = 0; s < len; s++)
                run_sweep(mask, ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 15)) : -1);
        end
        run_n(16'h0000, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
